// File: rtl/ps2_kb_frontend_if.sv
// PS/2 pins plus the FWFT pop port between the keyboard front end and its consumer.
// slave is the front end's view; master is the driving/consuming side.
interface ps2_kb_frontend_if;
    logic       ps2d;
    logic       ps2c;
    logic       rd_fifo;
    logic [8:0] rd_data;
    logic       fifo_empty;
    logic       frame_err;
    logic       overflow;

    modport slave (
        input  ps2d, ps2c, rd_fifo,
        output rd_data, fifo_empty, frame_err, overflow
    );

    modport master (
        output ps2d, ps2c, rd_fifo,
        input  rd_data, fifo_empty, frame_err, overflow
    );
endinterface

// File: rtl/ps2_kb_frontend.sv
// PS/2 keyboard receiver: sync, deglitch, deframe, drop break codes, queue {shift, make code}.
// Entry visible 1 cycle after rx_done; a full FIFO drops new make codes and pulses overflow.
module ps2_kb_frontend #(
    parameter int FIFO_ADDR_W = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    ps2_kb_frontend_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic             r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic             r_c_flt, r_fall;
    logic [FLT_W-1:0] r_flt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_s1 <= 1'b0;
            r_c_s2 <= 1'b0;
            r_d_s1 <= 1'b0;
            r_d_s2 <= 1'b0;
        end else begin
            r_c_s1 <= bus.ps2c;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= bus.ps2d;
            r_d_s2 <= r_d_s1;
        end
    end

    // Counter tracks how long the synchronised clock has disagreed with the filtered one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_flt   <= 1'b0;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_c_s2 == r_c_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_LAST) begin
                r_c_flt   <= r_c_s2;
                r_flt_cnt <= '0;
                r_fall    <= ~r_c_s2;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    logic [1:0]       r_state;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shreg;
    logic             r_par;
    logic [TMO_W-1:0] r_tmo;
    logic             r_rx_done;
    logic [7:0]       r_rx_byte;
    logic             r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_rx_done   <= 1'b0;
            r_rx_byte   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == S_IDLE || r_fall) r_tmo <= '0;
            else                             r_tmo <= r_tmo + 1'b1;

            if (r_state != S_IDLE && !r_fall && r_tmo == TMO_LAST) begin
                r_state <= S_IDLE;
            end else if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_d_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shreg  <= {r_d_s2, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_d_s2;
                        r_state <= S_STOP;
                    end
                    default: begin
                        if (r_d_s2 && (^{r_shreg, r_par})) begin
                            r_rx_done <= 1'b1;
                            r_rx_byte <= r_shreg;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    logic w_is_shift, w_is_f0, w_is_e0, w_push;
    logic r_brk, r_shift;

    assign w_is_shift = (r_rx_byte == 8'h12) || (r_rx_byte == 8'h59);
    assign w_is_f0    = (r_rx_byte == 8'hF0);
    assign w_is_e0    = (r_rx_byte == 8'hE0);
    assign w_push     = r_rx_done && !w_is_f0 && !w_is_e0 && !r_brk && !w_is_shift;

    // E0 prefixes fall through untouched so an extended make/break is handled by its last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk   <= 1'b0;
            r_shift <= 1'b0;
        end else if (r_rx_done) begin
            if (w_is_f0) begin
                r_brk <= 1'b1;
            end else if (w_is_e0) begin
                r_brk <= r_brk;
            end else if (r_brk) begin
                if (w_is_shift) r_shift <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_is_shift) begin
                r_shift <= 1'b1;
            end
        end
    end

    logic [8:0]             r_mem [DEPTH];
    logic [FIFO_ADDR_W:0]   r_wptr, r_rptr;
    logic                   r_ovf;
    logic                   w_empty, w_full, w_pop, w_wr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_ADDR_W] != r_rptr[FIFO_ADDR_W]) &&
                     (r_wptr[FIFO_ADDR_W-1:0] == r_rptr[FIFO_ADDR_W-1:0]);
    assign w_pop   = bus.rd_fifo && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_mem[r_wptr[FIFO_ADDR_W-1:0]] <= {r_shift, r_rx_byte};
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    assign bus.rd_data    = r_mem[r_rptr[FIFO_ADDR_W-1:0]];
    assign bus.fifo_empty = w_empty;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_kb_frontend.sv
// Randomised PS/2 frame stimulus against a queue-based keyboard/FIFO reference model.
module tb_ps2_kb_frontend;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FLEN  = 8;
    localparam int TMO   = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_kb_frontend_if kb();

    ps2_kb_frontend #(
        .FIFO_ADDR_W (AW),
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kb)
    );

    int n_cmp = 0, n_bad = 0;
    int n_ferr = 0, n_ovf = 0, exp_ferr = 0, exp_ovf = 0;
    int lat = 0;
    logic [8:0] mq[$];
    bit m_brk = 1'b0, m_shift = 1'b0;

    always @(negedge clk) begin
        if (kb.frame_err) n_ferr++;
        if (kb.overflow)  n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Keyboard behaviour from the byte stream: break prefix, shift state, bounded queue.
    function automatic void ref_byte(input logic [7:0] b, input bit good, input bit coinc);
        if (coinc && mq.size() > 0) void'(mq.pop_front());
        if (!good) begin
            exp_ferr++;
            return;
        end
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) begin end
        else if (m_brk) begin
            if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
        else if (mq.size() == DEPTH) exp_ovf++;
        else mq.push_back({m_shift, b});
    endfunction

    // mode 1 measures push latency from this falling edge; mode 2 pops exactly at the push edge.
    task automatic send_bit(input bit b, input int mode, input bit glitch);
        int h;
        h = $urandom_range(24, 30);
        kb.ps2d = b;
        tick(h);
        kb.ps2c = 1'b0;
        if (mode == 1) begin
            lat = 0;
            for (int k = 1; k <= h; k++) begin
                tick(1);
                if (lat == 0 && !kb.fifo_empty) lat = k;
            end
        end else if (mode == 2) begin
            tick(lat - 1);
            kb.rd_fifo = 1'b1;
            tick(1);
            kb.rd_fifo = 1'b0;
            tick(h - lat);
        end else if (glitch) begin
            tick(14);
            kb.ps2c = 1'b1;
            tick(3);
            kb.ps2c = 1'b0;
            tick(h - 17);
        end else begin
            tick(h);
        end
        kb.ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int stop_mode);
        bit p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0, 0, $urandom_range(0, 3) == 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0, $urandom_range(0, 3) == 0);
        send_bit(p, 0, $urandom_range(0, 3) == 0);
        send_bit(!bad_stop, stop_mode, 1'b0);
        kb.ps2d = 1'b1;
        tick(30);
        ref_byte(b, !bad_par && !bad_stop, stop_mode == 2);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_empty"}, kb.fifo_empty, mq.size() == 0);
        if (mq.size() != 0) chk({tag, "_head"}, kb.rd_data, mq[0]);
        chk({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
        chk({tag, "_ovf_cnt"}, n_ovf, exp_ovf);
    endtask

    task automatic pop_check();
        if (mq.size() == 0) begin
            chk("pop_on_empty", kb.fifo_empty, 1);
        end else begin
            chk("pop_not_empty", kb.fifo_empty, 0);
            chk("pop_data", kb.rd_data, mq.pop_front());
        end
        kb.rd_fifo = 1'b1;
        tick(1);
        kb.rd_fifo = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_data", kb.rd_data, 9'h000);
        chk("rst_empty", kb.fifo_empty, 1);
        chk("rst_frame_err", kb.frame_err, 0);
        chk("rst_overflow", kb.overflow, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill[5];
        logic [7:0] b;
        int r;
        fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        kb.ps2c = 1'b1;
        kb.ps2d = 1'b1;
        kb.rd_fifo = 1'b0;
        rst_n = 1'b0;
        tick(5);
        check_reset_outputs();
        rst_n = 1'b1;
        tick(30);
        check_state("idle");

        send_frame(8'h34, 0, 0, 1);
        chk("latency_measured", lat > 0, 1);
        check_state("make34");
        pop_check();
        chk("empty_after_pop", kb.fifo_empty, 1);

        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h34, 0, 0, 0);
        check_state("break34");

        send_frame(8'h12, 0, 0, 0);
        send_frame(8'h21, 0, 0, 0);
        check_state("shift21");
        pop_check();
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h12, 0, 0, 0);
        send_frame(8'h21, 0, 0, 0);
        check_state("unshift21");
        pop_check();
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h4D, 0, 0, 0);
        check_state("ext4d");
        pop_check();

        send_frame(8'h21, 1, 0, 0);
        check_state("bad_parity");
        send_frame(8'h21, 0, 1, 0);
        check_state("bad_stop");
        send_frame(8'h21, 0, 0, 0);
        check_state("good_after_err");
        pop_check();

        foreach (fill[i]) send_frame(fill[i], 0, 0, 0);
        check_state("overflow");
        repeat (DEPTH + 1) pop_check();

        for (int i = 0; i < DEPTH; i++) send_frame(fill[i], 0, 0, 0);
        check_state("full_again");
        send_frame(8'h2C, 0, 0, 2);
        check_state("push_pop_full");
        repeat (DEPTH + 1) pop_check();

        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
        kb.ps2d = 1'b1;
        tick(TMO + 300);
        check_state("timeout");
        send_frame(8'h34, 0, 0, 0);
        check_state("after_timeout");
        pop_check();

        kb.ps2d = 1'b0;
        tick(5);
        repeat (3) begin
            kb.ps2c = 1'b0;
            tick(FLEN - 3);
            kb.ps2c = 1'b1;
            tick(20);
        end
        kb.ps2d = 1'b1;
        tick(20);
        check_state("glitch");
        send_frame(8'h1C, 0, 0, 0);
        check_state("after_glitch");
        pop_check();

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'h12;
                1: b = 8'h59;
                2: b = 8'hF0;
                3: b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            r = $urandom_range(0, 11);
            send_frame(b, r == 0, r == 1, 0);
            check_state("rand");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) pop_check();
        end
        while (mq.size() != 0) pop_check();

        send_frame(8'h12, 0, 0, 0);
        send_frame(8'h33, 0, 0, 0);
        check_state("pre_reset");
        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0);
        rst_n = 1'b0;
        tick(3);
        check_reset_outputs();
        rst_n = 1'b1;
        mq.delete();
        m_brk = 1'b0;
        m_shift = 1'b0;
        kb.ps2d = 1'b1;
        tick(30);
        check_state("post_reset");
        send_frame(8'h1C, 0, 0, 0);
        check_state("post_reset_frame");
        pop_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_kb_frontend.md
Name: ps2_kb_frontend

Overview:
PS/2 keyboard receive front end that feeds the command-decode stage through a small first-word-fall-through (FWFT) FIFO.
- Synchronises and deglitches ps2c/ps2d, deserialises 11-bit frames, and checks parity and the stop bit.
- Strips break sequences and tracks the Shift key, so only make codes are queued.
- Each queued entry is {shift, scan code}; the consumer pops entries with rd_fifo.

Parameters:
FIFO_ADDR_W, 2, FIFO depth is 2**FIFO_ADDR_W entries.
FILTER_LEN, 8, number of consecutive equal synchronised ps2c samples needed to change the filtered clock.
TIMEOUT_CYC, 50000, clk cycles with no ps2c falling edge before a partial frame is aborted.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
ps2d  in  1  PS/2 data, asynchronous
ps2c  in  1  PS/2 clock, asynchronous
rd_fifo  in  1  pop request for the FIFO head
rd_data  out  9  FIFO head as {shift, code[7:0]}; valid only while fifo_empty=0
fifo_empty  out  1  FIFO holds no entries
frame_err  out  1  one-cycle pulse on a parity or stop-bit error
overflow  out  1  one-cycle pulse when a make code is dropped because the FIFO is full

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All registers clear, FIFO memory clears, FSMs go to IDLE, shift=0.
- Reset outputs: rd_data=9'h000, fifo_empty=1, frame_err=0, overflow=0.
- Reset mid-frame discards the partial frame and all queued entries.
- Input sync: ps2c and ps2d each pass through 2-FF synchronisers.
- Clock filter: filtered ps2c goes to 1 after FILTER_LEN consecutive synchronised 1s, to 0 after FILTER_LEN consecutive 0s, and holds otherwise.
- fall = filtered ps2c 1->0, registered as a single-cycle strobe.
- Frame format: start 0, data LSB-first, odd parity, stop 1.
- Receiver FSM:
  - IDLE: on fall with ps2d=0 -> DATA, bit count=0. On fall with ps2d=1, stay in IDLE (spurious edge).
  - DATA: on each fall, shift ps2d into the MSB of the shift register. After the 8th bit -> PARITY.
  - PARITY: on fall, latch the parity bit -> STOP.
  - STOP: on fall, check the frame. Good means stop=1 and the 9 data+parity bits contain an odd number of 1s.
    - Good frame: rx_done pulses 1 cycle with the byte.
    - Bad frame: frame_err pulses 1 cycle, nothing is pushed.
    - Either way -> IDLE.
  - Timeout: in DATA, PARITY or STOP, TIMEOUT_CYC cycles without a fall -> IDLE, silently (no frame_err). The counter restarts on every fall.
- Code filter, evaluated on rx_done (the byte arriving this cycle):
  - Byte 8'hF0: set brk, push nothing.
  - Byte 8'hE0: ignored. brk is unchanged and the next byte is handled normally.
  - brk=1, any other byte (release): if the byte is 8'h12 or 8'h59, clear shift; otherwise discard. Then clear brk. Nothing is pushed.
  - brk=0, byte 8'h12 or 8'h59: set shift, push nothing.
  - brk=0, any other byte: push {shift, byte}. Typematic repeats push every time.
- FIFO:
  - FWFT: rd_data shows the head entry combinationally from the registered read pointer.
  - Pop takes effect at the clock edge where rd_fifo=1 and fifo_empty=0. rd_fifo while empty is ignored.
  - Push while full with no pop: entry dropped, overflow pulses 1 cycle.
  - Push and pop in the same cycle while full: both happen, the count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push happens, the pop is ignored.
  - Pointers are FIFO_ADDR_W+1 bits wide and wrap naturally. Full/empty come from the MSB comparison.
- Latency: the pushed entry is visible (fifo_empty=0) 1 cycle after the rx_done pulse. rx_done follows the stop-bit fall by 1 cycle.

Test Plan:
- Make code: clean frame 0x34 (bits 0,0,1,0,1,1,0,0, parity 0, stop 1) -> fifo_empty=0, rd_data=9'h034. Pulse rd_fifo -> fifo_empty=1.
- Break suppression: frames F0, 34 after the make -> no new entry, frame_err stays 0, exactly one 9'h034 is queued in total.
- Shift tracking:
  - Frames 12, 21 -> single entry 9'h121.
  - Then F0 12, 21 -> next entry 9'h021.
  - E0 followed by 4D -> entry 9'h04D.
- Frame errors:
  - Frame 0x21 with parity bit 0 -> frame_err pulses once, FIFO stays empty.
  - Frame 0x21 with stop bit 0 -> frame_err pulses once, FIFO stays empty.
  - A following good 0x21 frame -> 9'h021 is queued.
- Overflow and wrap:
  - 5 make codes 0x15,0x1D,0x24,0x2D,0x2C with no reads -> overflow pulses on the 5th. Popping then returns 015,01D,024,02D in order, then fifo_empty=1.
  - Push coincident with pop while full -> no overflow.
- Timeout and glitch:
  - Start bit plus 4 data bits, then ps2c idle for more than TIMEOUT_CYC -> no error and no entry; the next full 0x34 frame is received correctly.
  - ps2c glitch lasting fewer than FILTER_LEN cycles -> no edge is detected.
  - rst_n asserted mid-frame -> all reset values hold, fifo_empty=1.
